// File: rtl/bist_session_sequencer.sv
// BIST session sequencer: start -> INIT -> RUN -> CAPTURE -> serial status/signature frame.
// Optional per-session statistics counters are enabled by defining BIST_SESSION_STATS_EN.
module bist_session_sequencer #(
  parameter int unsigned      SIG_W       = 4,
  parameter logic [SIG_W-1:0] GOLDEN_SIG  = 4'b0011,
  parameter int unsigned      TIMEOUT_CYC = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             finish,
  input  logic [SIG_W-1:0] signature,
  output logic             bist_rst,
  output logic             testmode,
  output logic             busy,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             fault_detected,
  output logic [SIG_W-1:0] sig_hold
`ifdef BIST_SESSION_STATS_EN
  ,
  output logic [7:0]       session_cnt,
  output logic [7:0]       fail_cnt
`endif
);

  localparam int unsigned FRAME_W = SIG_W + 2;
  localparam int unsigned CntW    = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned IdxW    = $clog2(FRAME_W);

  typedef enum logic [2:0] {StIdle, StInit, StRun, StCapture, StShift} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 timeout_q, timeout_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic                 fault_q, fault_d;
  logic [SIG_W-1:0]     sig_hold_q, sig_hold_d;
  logic                 bist_rst_q, bist_rst_d;
  logic                 testmode_q, testmode_d;
  logic                 busy_q, busy_d;
  logic                 sout_q, sout_d;
  logic                 sout_valid_q, sout_valid_d;
  logic                 fault_flag;
`ifdef BIST_SESSION_STATS_EN
  logic [7:0]           session_q, session_d;
  logic [7:0]           fail_q, fail_d;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    timeout_d  = timeout_q;
    frame_d    = frame_q;
    idx_d      = idx_q;
    fault_d    = fault_q;
    sig_hold_d = sig_hold_q;
    fault_flag = 1'b0;
`ifdef BIST_SESSION_STATS_EN
    session_d  = session_q;
    fail_d     = fail_q;
`endif

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StInit;
          cnt_d   = '0;
        end
      end
      StInit: begin
        if (cnt_q == CntW'(1)) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRun: begin
        // finish takes priority over the timeout limit in the same cycle
        if (finish) begin
          state_d   = StCapture;
          timeout_d = 1'b0;
        end else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
          state_d   = StCapture;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StCapture: begin
        fault_flag = (signature != GOLDEN_SIG) | timeout_q;
        sig_hold_d = signature;
        fault_d    = fault_flag;
        frame_d    = {timeout_q, fault_flag, signature};
        idx_d      = IdxW'(FRAME_W - 1);
        cnt_d      = '0;
        state_d    = StShift;
`ifdef BIST_SESSION_STATS_EN
        if (session_q != 8'hFF) session_d = session_q + 8'd1;
        if (fault_flag && (fail_q != 8'hFF)) fail_d = fail_q + 8'd1;
`endif
      end
      StShift: begin
        // sout_valid is always high in this state, so ready alone means a transfer
        if (sout_ready) begin
          if (idx_q == '0) begin
            state_d = StIdle;
          end else begin
            idx_d   = idx_q - IdxW'(1);
            frame_d = {frame_q[FRAME_W-2:0], 1'b0};
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered copies decoded from the next state
    bist_rst_d   = (state_d != StInit);
    testmode_d   = (state_d == StRun);
    busy_d       = (state_d != StIdle);
    sout_valid_d = (state_d == StShift);
    sout_d       = (state_d == StShift) ? frame_d[FRAME_W-1] : 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
      frame_q      <= '0;
      idx_q        <= '0;
      fault_q      <= 1'b0;
      sig_hold_q   <= '0;
      bist_rst_q   <= 1'b1;
      testmode_q   <= 1'b0;
      busy_q       <= 1'b0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
`ifdef BIST_SESSION_STATS_EN
      session_q    <= '0;
      fail_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      timeout_q    <= timeout_d;
      frame_q      <= frame_d;
      idx_q        <= idx_d;
      fault_q      <= fault_d;
      sig_hold_q   <= sig_hold_d;
      bist_rst_q   <= bist_rst_d;
      testmode_q   <= testmode_d;
      busy_q       <= busy_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
`ifdef BIST_SESSION_STATS_EN
      session_q    <= session_d;
      fail_q       <= fail_d;
`endif
    end
  end

  assign bist_rst       = bist_rst_q;
  assign testmode       = testmode_q;
  assign busy           = busy_q;
  assign sout           = sout_q;
  assign sout_valid     = sout_valid_q;
  assign fault_detected = fault_q;
  assign sig_hold       = sig_hold_q;
`ifdef BIST_SESSION_STATS_EN
  assign session_cnt    = session_q;
  assign fail_cnt       = fail_q;
`endif

endmodule

// File: doc/bist_session_sequencer.md
Name: bist_session_sequencer

Overview:
Tester-facing end of the BIST path. On a start request it:
- resets the pattern generator and signature register,
- drives testmode for one full LFSR period and waits for finish,
- captures and checks the MISR signature against the golden value,
- returns a status+signature frame to the tester bit-serially over a valid/ready handshake.

Parameters:
SIG_W, 4, signature width in bits
GOLDEN_SIG, 4'b0011, expected fault-free signature
TIMEOUT_CYC, 15, max RUN cycles allowed without finish before aborting
FRAME_W, SIG_W+2, serial frame length: {timeout_flag, fault_flag, signature}

Ports:
clock  input  1  single system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
start  input  1  session request, sampled only in IDLE
finish  input  1  end-of-sequence strobe from pattern generator
signature  input  SIG_W  MISR output, sampled in CAPTURE
bist_rst  output  1  active-low reset to LFSR/MISR
testmode  output  1  selects LFSR patterns into CUT
busy  output  1  high in any state except IDLE
sout  output  1  serial frame data, MSB first
sout_valid  output  1  sout holds a valid bit
sout_ready  input  1  tester accepts current bit
fault_detected  output  1  last session failed, signature mismatch or timeout
sig_hold  output  SIG_W  last captured signature

Behaviour:
- Reset (reset==0 at a clock edge) from any state:
  - state=IDLE, bist_rst=1, testmode=0, busy=0, sout=0, sout_valid=0, fault_detected=0, sig_hold=0, all counters 0.
  - An in-progress session is abandoned. No partial frame is emitted.
- FSM states: IDLE, INIT, RUN, CAPTURE, SHIFT.
- IDLE:
  - start==1 -> INIT next cycle.
  - start in any other state is ignored; no queuing.
- INIT:
  - Lasts exactly 2 cycles; bist_rst=0, testmode=0.
  - Then -> RUN.
- RUN:
  - bist_rst=1, testmode=1. Cycle counter starts at 0 on entry and increments each cycle.
  - finish==1 -> CAPTURE next cycle.
  - Counter reaches TIMEOUT_CYC-1 with finish still 0 -> CAPTURE with timeout_flag=1.
  - finish and the timeout limit in the same cycle -> finish wins; timeout_flag=0.
- CAPTURE (1 cycle):
  - testmode=0.
  - sig_hold<=signature.
  - fault_flag=(signature!=GOLDEN_SIG)|timeout_flag.
  - fault_detected<=fault_flag.
  - Load shift register with {timeout_flag, fault_flag, signature}.
  - Bit index=FRAME_W-1. Then -> SHIFT.
- SHIFT:
  - sout_valid=1, sout=current frame bit.
  - A bit transfers on any cycle with sout_valid&&sout_ready; the next bit is presented the following cycle.
  - While sout_ready==0, sout and sout_valid hold steady.
  - After the last bit (index 0) transfers -> IDLE, sout_valid=0 in the same cycle as the IDLE entry.
  - Minimum frame time is FRAME_W cycles.
- fault_detected and sig_hold:
  - Hold until the next CAPTURE or reset.
  - Not cleared by start.
- Latency, start to first sout_valid with finish arriving N cycles into RUN: 1 (IDLE->INIT) + 2 (INIT) + N + 1 (CAPTURE).
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
BIST_SESSION_STATS_EN
- Defined:
  - Adds output ports session_cnt[7:0] and fail_cnt[7:0], both reset to 0.
  - session_cnt increments on each CAPTURE.
  - fail_cnt increments on CAPTURE when fault_flag=1.
  - Both saturate at 8'hFF; no wrap.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
1. Golden run: start pulse, finish 7 cycles into RUN, signature=4'b0011.
   -> Frame bits in order 0,0,0,0,1,1; fault_detected=0; sig_hold=4'b0011.
2. Faulty CUT: same as test 1 but signature=4'b0110.
   -> Frame 0,1,0,1,1,0; fault_detected=1.
3. Timeout: finish held 0.
   -> testmode high exactly 15 cycles, then frame begins with 1,1; fault_detected=1.
4. Backpressure: sout_ready toggles 1,0,0,1 pattern during SHIFT.
   -> No bit lost or duplicated; sout stable while ready=0; busy stays 1 until the last bit transfers.
5. Reset mid-RUN: reset=0 for 1 cycle at RUN cycle 3.
   -> Next cycle IDLE, testmode=0, sout_valid=0, fault_detected retains 0; start is accepted again afterwards.
6. Simultaneous events:
   - finish and timeout limit in the same cycle -> timeout_flag=0.
   - start pulsed during SHIFT -> ignored; no second session.
